// File: rtl/wb_gpio_irq.sv
// ============================================================================
// Module      : wb_gpio_irq
// Description : Wishbone GPIO with edge-selectable, sticky W1C interrupt status
//               and a level interrupt output. Define WBGPIO_DEBOUNCE_EN to add
//               a per-input debounce filter between synchroniser and edge logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_gpio_irq #(
    parameter int          NIN      = 16,
    parameter int          NOUT     = 16,
    parameter logic [15:0] DEFAULT  = 16'h0,
    parameter int          DEBOUNCE = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_wb_cyc,
    input  logic            i_wb_stb,
    input  logic            i_wb_we,
    input  logic [1:0]      i_wb_addr,
    input  logic [31:0]     i_wb_data,
    output logic            o_wb_ack,
    output logic            o_wb_stall,
    output logic [31:0]     o_wb_data,
    input  logic [NIN-1:0]  i_gpio,
    output logic [NOUT-1:0] o_gpio,
    output logic            o_int
);

    localparam logic [1:0] c_addr_data = 2'd0;
    localparam logic [1:0] c_addr_ien  = 2'd1;
    localparam logic [1:0] c_addr_stat = 2'd2;
    localparam logic [1:0] c_addr_edg  = 2'd3;

    logic [NIN-1:0]  r_sync_x;
    logic [NIN-1:0]  r_sync_r;
    logic [NIN-1:0]  w_din;
    logic [NIN-1:0]  r_prev;
    logic [NIN-1:0]  w_rise;
    logic [NIN-1:0]  w_fall;
    logic [NIN-1:0]  w_hit;
    logic [NIN-1:0]  w_clr;
    logic [NIN-1:0]  r_ien;
    logic [NIN-1:0]  r_stat;
    logic [NIN-1:0]  r_edge_r;
    logic [NIN-1:0]  r_edge_f;
    logic [NOUT-1:0] r_gpio;
    logic            r_ack;
    logic            r_int;
    logic [31:0]     r_rdata;
    logic [31:0]     w_rdata;
    logic            w_stb;
    logic            w_wr;

    assign w_stb = i_wb_cyc & i_wb_stb;
    assign w_wr  = w_stb & i_wb_we;

    // Two-flop synchroniser for the asynchronous inputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync_x <= '0;
            r_sync_r <= '0;
        end else begin
            r_sync_x <= i_gpio;
            r_sync_r <= r_sync_x;
        end
    end

`ifdef WBGPIO_DEBOUNCE_EN
    localparam int c_cw = $clog2(DEBOUNCE);

    logic [NIN-1:0] w_deb;

    for (genvar gi = 0; gi < NIN; gi++) begin : g_deb
        logic [c_cw-1:0] r_cnt;
        logic            r_bit;

        // Follow r only once it has disagreed for DEBOUNCE consecutive cycles
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_cnt <= '0;
                r_bit <= 1'b0;
            end else if (r_sync_r[gi] == r_bit) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cw'(DEBOUNCE - 1)) begin
                r_cnt <= '0;
                r_bit <= r_sync_r[gi];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_deb[gi] = r_bit;
    end

    assign w_din = w_deb;
`else
    assign w_din = r_sync_r;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_din;
        end
    end

    assign w_rise = w_din & ~r_prev;
    assign w_fall = ~w_din & r_prev;
    assign w_hit  = (w_rise & r_edge_r) | (w_fall & r_edge_f);
    assign w_clr  = (w_wr && i_wb_addr == c_addr_stat) ? i_wb_data[NIN-1:0] : '0;

    // Read data reflects state before any write in the same cycle
    always_comb begin
        w_rdata = '0;
        case (i_wb_addr)
            c_addr_data: begin
                w_rdata[NIN+15:16] = w_din;
                w_rdata[NOUT-1:0]  = r_gpio;
            end
            c_addr_ien: begin
                w_rdata[NIN-1:0] = r_ien;
            end
            c_addr_stat: begin
                w_rdata[NIN-1:0] = r_stat;
            end
            default: begin
                w_rdata[NIN-1:0]   = r_edge_r;
                w_rdata[NIN+15:16] = r_edge_f;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_gpio   <= DEFAULT[NOUT-1:0];
            r_ien    <= '0;
            r_edge_r <= '1;
            r_edge_f <= '1;
        end else if (w_wr) begin
            case (i_wb_addr)
                c_addr_data: r_gpio <= (r_gpio & ~i_wb_data[NOUT+15:16])
                                     | (i_wb_data[NOUT-1:0] & i_wb_data[NOUT+15:16]);
                c_addr_ien:  r_ien  <= i_wb_data[NIN-1:0];
                c_addr_edg: begin
                    r_edge_r <= i_wb_data[NIN-1:0];
                    r_edge_f <= i_wb_data[NIN+15:16];
                end
                default: ;
            endcase
        end
    end

    // New edges take priority over a simultaneous write-1-to-clear
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stat <= '0;
            r_int  <= 1'b0;
        end else begin
            r_stat <= (r_stat & ~w_clr) | w_hit;
            r_int  <= |(r_stat & r_ien);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= w_stb;
            if (w_stb) begin
                r_rdata <= w_rdata;
            end
        end
    end

    assign o_wb_ack   = r_ack;
    assign o_wb_stall = 1'b0;
    assign o_wb_data  = r_rdata;
    assign o_gpio     = r_gpio;
    assign o_int      = r_int;

endmodule

`default_nettype wire

// File: tb/tb_wb_gpio_irq.sv
// ============================================================================
// Module      : tb_wb_gpio_irq
// Description : Directed bench for wb_gpio_irq; read responses are queued at
//               issue time and checked by an independent ack monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_gpio_irq;

    localparam int          NIN  = 16;
    localparam int          NOUT = 16;
    localparam logic [15:0] DEF  = 16'h00A5;
    localparam int          DEB  = 16;
`ifdef WBGPIO_DEBOUNCE_EN
    localparam int c_lat = DEB;
`else
    localparam int c_lat = 0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            wb_cyc = 1'b0;
    logic            wb_stb = 1'b0;
    logic            wb_we = 1'b0;
    logic [1:0]      wb_addr = 2'd0;
    logic [31:0]     wb_wdata = '0;
    logic            wb_ack;
    logic            wb_stall;
    logic [31:0]     wb_rdata;
    logic [NIN-1:0]  gpio_in = '0;
    logic [NOUT-1:0] gpio_out;
    logic            irq;

    wb_gpio_irq #(
        .NIN      (NIN),
        .NOUT     (NOUT),
        .DEFAULT  (DEF),
        .DEBOUNCE (DEB)
    ) u_dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wb_cyc   (wb_cyc),
        .i_wb_stb   (wb_stb),
        .i_wb_we    (wb_we),
        .i_wb_addr  (wb_addr),
        .i_wb_data  (wb_wdata),
        .o_wb_ack   (wb_ack),
        .o_wb_stall (wb_stall),
        .o_wb_data  (wb_rdata),
        .i_gpio     (gpio_in),
        .o_gpio     (gpio_out),
        .o_int      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        is_rd;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic exp_ack  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic rd, input logic [31:0] d, input string name);
        exp_t e;
        e.data  = d;
        e.is_rd = rd;
        e.name  = name;
        sb.push_back(e);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = a; wb_wdata = d;
        push(1'b0, d, "write");
        tick(1);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = a; wb_wdata = ~exp;
        push(1'b1, exp, name);
        tick(1);
        wb_cyc = 1'b0; wb_stb = 1'b0;
    endtask

    // Strobe issued in the same cycle as reset: must never be acknowledged
    task automatic reset_with_strobe();
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 2'd0; rst = 1'b1;
        tick(1);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        tick(1);
        rst = 1'b0;
    endtask

    always @(posedge clk) exp_ack <= wb_cyc && wb_stb && !rst;

    always @(negedge clk) begin : mon
        exp_t e;
        chk("ack_timing", {31'd0, wb_ack}, {31'd0, exp_ack});
        if (wb_ack) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack actual=ack required=no_ack");
            end else begin
                e = sb.pop_front();
                if (e.is_rd) chk(e.name, wb_rdata, e.data);
            end
        end
    end

    initial begin
        // 1: reset values
        tick(3);
        chk("rst_gpio", {16'd0, gpio_out}, {16'd0, DEF});
        chk("rst_int", {31'd0, irq}, 32'd0);
        chk("rst_rdata", wb_rdata, 32'd0);
        chk("stall", {31'd0, wb_stall}, 32'd0);
        rst = 1'b0;
        rd(2'd0, {16'h0000, DEF}, "rst_data");
        rd(2'd3, 32'hFFFF_FFFF, "rst_edge");
        rd(2'd1, 32'd0, "rst_ien");
        rd(2'd2, 32'd0, "rst_stat");

        // 2: masked output writes
        wr(2'd0, 32'hFFFF_0000);
        chk("gpio_zero", {16'd0, gpio_out}, 32'h0000);
        wr(2'd0, 32'h0003_0001);
        chk("gpio_w1", {16'd0, gpio_out}, 32'h0001);
        wr(2'd0, 32'h0002_0002);
        chk("gpio_w2", {16'd0, gpio_out}, 32'h0003);
        wr(2'd0, 32'h0001_0000);
        chk("gpio_w3", {16'd0, gpio_out}, 32'h0002);
        rd(2'd0, 32'h0000_0002, "data_rd");

        // 3: rise-only edge on bit 0, interrupt latency
        wr(2'd3, 32'h0000_0001);
        wr(2'd1, 32'h0000_0001);
        rd(2'd2, 32'd0, "stat_idle");
        gpio_in[0] = 1'b1;
        tick(3 + c_lat);
        chk("int_early", {31'd0, irq}, 32'd0);
        tick(1);
        chk("int_rise", {31'd0, irq}, 32'd1);
        rd(2'd2, 32'd1, "stat_rise");
        gpio_in[0] = 1'b0;
        tick(8 + c_lat);
        rd(2'd2, 32'd1, "stat_norisefall");
        chk("int_held", {31'd0, irq}, 32'd1);

        // 4: clear coinciding with a new edge, then a plain clear
        gpio_in[0] = 1'b1;
        tick(2 + c_lat);
        wr(2'd2, 32'd1);
        chk("int_setwins", {31'd0, irq}, 32'd1);
        rd(2'd2, 32'd1, "stat_setwins");
        wr(2'd2, 32'd1);
        chk("int_before_clr", {31'd0, irq}, 32'd1);
        tick(1);
        chk("int_cleared", {31'd0, irq}, 32'd0);
        rd(2'd2, 32'd0, "stat_cleared");

        // 5: status latches while disabled, enable raises interrupt
        wr(2'd1, 32'd0);
        wr(2'd3, 32'hFFFF_FFFF);
        gpio_in[5] = 1'b1;
        tick(4 + c_lat);
        gpio_in[5] = 1'b0;
        tick(4 + c_lat);
        rd(2'd2, 32'h0000_0020, "stat_bit5");
        chk("int_disabled", {31'd0, irq}, 32'd0);
        wr(2'd1, 32'h0000_0020);
        chk("int_en_lag", {31'd0, irq}, 32'd0);
        tick(1);
        chk("int_en", {31'd0, irq}, 32'd1);
        rd(2'd0, 32'h0001_0002, "data_in");

        // fall-only edge select, unused-bit masking, back-to-back strobes
        wr(2'd2, 32'hFFFF_FFFF);
        wr(2'd1, 32'd0);
        wr(2'd3, 32'h0008_0000);
        gpio_in[3] = 1'b1;
        tick(4 + c_lat);
        rd(2'd2, 32'd0, "stat_fall_norise");
        gpio_in[3] = 1'b0;
        tick(4 + c_lat);
        rd(2'd2, 32'h0000_0008, "stat_fall");
        wr(2'd1, 32'hFFFF_FFFF);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 2'd1;
        push(1'b1, 32'h0000_FFFF, "b2b_ien");
        tick(1);
        wb_addr = 2'd2;
        push(1'b1, 32'h0000_0008, "b2b_stat");
        tick(1);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        tick(1);
        chk("int_fall", {31'd0, irq}, 32'd1);

        // reset in the middle of a transaction and of an input pulse
        gpio_in[7] = 1'b1;
        tick(2);
        gpio_in = '0;
        reset_with_strobe();
        chk("rst2_gpio", {16'd0, gpio_out}, {16'd0, DEF});
        chk("rst2_int", {31'd0, irq}, 32'd0);
        tick(4);
        rd(2'd1, 32'd0, "rst2_ien");
        rd(2'd2, 32'd0, "rst2_stat");
        rd(2'd3, 32'hFFFF_FFFF, "rst2_edge");
        rd(2'd0, {16'h0000, DEF}, "rst2_data");

`ifdef WBGPIO_DEBOUNCE_EN
        // 6: debounce filtering
        gpio_in[2] = 1'b1;
        tick(10);
        gpio_in[2] = 1'b0;
        tick(40);
        rd(2'd2, 32'd0, "deb_short");
        gpio_in[2] = 1'b1;
        tick(20);
        gpio_in[2] = 1'b0;
        tick(40);
        rd(2'd2, 32'h0000_0004, "deb_long");
        wr(2'd1, 32'h0000_0004);
        gpio_in[2] = 1'b1;
        tick(10);
        gpio_in = '0;
        reset_with_strobe();
        tick(40);
        rd(2'd2, 32'd0, "deb_rst_stat");
        rd(2'd1, 32'd0, "deb_rst_ien");
        chk("deb_rst_int", {31'd0, irq}, 32'd0);
`endif

        tick(3);
        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
